// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one request at a time, word/byte lanes,
// optional indirect (pointer-then-data) access, misaligned words flagged.
module mem_access_unit #(
    parameter int DATA_W = 16,
    localparam int LANES = DATA_W / 8,
    parameter bit INDIRECT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic              req_indirect,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LANES-1:0]  mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, PTR, DATA, RESP} state_t;
    state_t state, state_nx;

    logic              wr_q, byte_q, sgn_q, ind_q, err_q;
    logic [DATA_W-1:0] addr_q, wdata_q, ptr_q, rdata_q;
    logic [DATA_W-1:0] eff_addr, load_val;
    logic [LW-1:0]     lane;
    logic [7:0]        rd_byte;
    logic              ind_req, acc_misalign, ptr_misalign;

    assign ind_req      = req_indirect & INDIRECT_EN;
    // Pointer words must be aligned, so any indirect request with lane bits set fails at accept.
    assign acc_misalign = (req_addr[LW-1:0] != '0) && (ind_req || !req_byte);
    assign ptr_misalign = !byte_q && (mem_rdata[LW-1:0] != '0);
    assign eff_addr     = ind_q ? ptr_q : addr_q;
    assign lane         = eff_addr[LW-1:0];

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == i[LW-1:0]) rd_byte = mem_rdata[8*i +: 8];
        end
        load_val = byte_q ? {{(DATA_W-8){sgn_q & rd_byte[7]}}, rd_byte} : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            ind_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    byte_q  <= req_byte;
                    sgn_q   <= req_signed;
                    ind_q   <= ind_req;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err_q   <= acc_misalign;
                    rdata_q <= '0;
                end
                PTR: if (mem_resp) begin
                    ptr_q <= mem_rdata;
                    err_q <= ptr_misalign;
                end
                DATA: if (mem_resp) rdata_q <= wr_q ? '0 : load_val;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx        = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_err         = 1'b0;
        rsp_rdata       = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = acc_misalign ? RESP : (ind_req ? PTR : DATA);
            end
            PTR: begin
                mem_read        = 1'b1;
                mem_addr        = addr_q;
                mem_byte_enable = '1;
                if (mem_resp) state_nx = ptr_misalign ? RESP : DATA;
            end
            DATA: begin
                mem_addr = eff_addr;
                if (wr_q) begin
                    mem_write = 1'b1;
                    if (byte_q) begin
                        mem_byte_enable = {{(LANES-1){1'b0}}, 1'b1} << lane;
                        mem_wdata       = {LANES{wdata_q[7:0]}};
                    end else begin
                        mem_byte_enable = '1;
                        mem_wdata       = wdata_q;
                    end
                end else begin
                    mem_read        = 1'b1;
                    mem_byte_enable = '1;
                end
                if (mem_resp) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = rdata_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
